// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the HD44780-style text LCD controller.
// The byte transmitter and the top-level refresh FSM both import this package.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] DDRAM    = 8'h80;
  localparam logic [7:0] LINE2    = 8'h40;
  localparam logic [7:0] SPACE    = 8'h20;

  localparam int INIT_LEN = 5;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_CHAR
  } lcd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_WAIT
  } tx_state_t;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: return FUNC_SET;
      3'd2:       return DISP_ON;
      3'd3:       return ENTRY;
      default:    return CLEAR;
    endcase
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Sends one byte to the LCD as SETUP, EN pulse, then a settle wait.
// A new START is accepted in the final wait cycle so bytes can run back to back.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int EN_CYC       = 12,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic       CLOCK,
  input  logic       SYNC_RST,
  input  logic       START,
  input  logic       RS,
  input  logic [7:0] DATA,
  input  logic       LONG,
  output logic       DONE,
  output logic       LCD_RS,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);

  localparam int CW = $clog2(max_of(max_of(EN_CYC, CMD_WAIT_CYC), CLR_WAIT_CYC) + 1);

  tx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_rs;
  logic            r_en;
  logic            r_long;
  logic [7:0]      r_data;

  logic [CW-1:0]   w_wait_last;
  logic            w_last;
  logic            w_accept;

  assign w_wait_last = r_long ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
  assign w_last      = (r_state == TX_WAIT) && (r_cnt == w_wait_last);
  assign w_accept    = START && ((r_state == TX_IDLE) || w_last);

  always_ff @(posedge CLOCK) begin
    if (!SYNC_RST) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_long  <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      // RS/DATA are captured here and held untouched until the next accept
      r_state <= TX_SETUP;
      r_cnt   <= '0;
      r_rs    <= RS;
      r_data  <= DATA;
      r_long  <= LONG;
      r_en    <= 1'b0;
    end else begin
      case (r_state)
        TX_SETUP: begin
          r_state <= TX_PULSE;
          r_en    <= 1'b1;
          r_cnt   <= '0;
        end
        TX_PULSE: begin
          if (r_cnt == CW'(EN_CYC - 1)) begin
            r_state <= TX_WAIT;
            r_en    <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        TX_WAIT: begin
          if (w_last) begin
            r_state <= TX_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign DONE     = w_last;
  assign LCD_RS   = r_rs;
  assign LCD_EN   = r_en;
  assign LCD_DATA = r_data;

endmodule

// File: rtl/lcd_text_ctrl.sv
// Character-buffer LCD controller: power-up wait, init sequence, then full
// redraws of the buffer whenever it has been written or a refresh is requested.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int  COLS         = 16,
  parameter int  ROWS         = 2,
  parameter int  PWR_WAIT_CYC = 750000,
  parameter int  EN_CYC       = 12,
  parameter int  CMD_WAIT_CYC = 2000,
  parameter int  CLR_WAIT_CYC = 82000,
  localparam int NCELL        = ROWS * COLS,
  // One spare code point so out-of-range addresses exist even for power-of-two sizes
  localparam int AW           = $clog2(NCELL + 1)
) (
  input  logic          CLOCK,
  input  logic          SYNC_RST,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [7:0]    WR_CHAR,
  input  logic          REFRESH,
  output logic          LCD_RS,
  output logic          LCD_RW,
  output logic          LCD_EN,
  output logic [7:0]    LCD_DATA,
  output logic          INIT_DONE,
  output logic          BUSY
);

  localparam int IW  = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW  = $clog2(PWR_WAIT_CYC + 1);

  lcd_state_t      r_state;
  logic [2:0]      r_idx;
  logic            r_row;
  logic [CLW-1:0]  r_col;
  logic [PW-1:0]   r_cnt;
  logic            r_dirty;
  logic            r_init_done;
  logic            r_busy;

  lcd_state_t      w_nstate;
  logic [2:0]      w_nidx;
  logic            w_nrow;
  logic [CLW-1:0]  w_ncol;
  logic            w_adv;
  logic            w_start;
  logic            w_rs;
  logic            w_long;
  logic [7:0]      w_data;
  logic [IW-1:0]   w_cell;
  logic            w_done;
  logic            w_wr_ok;
  logic            w_init_fin;
  logic            w_refresh_go;
  logic [7:0]      w_buf [NCELL];

  assign w_wr_ok = WR_EN && (WR_ADDR < AW'(NCELL));

  for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell
    logic [7:0] r_cell;
    always_ff @(posedge CLOCK) begin
      if (!SYNC_RST) begin
        r_cell <= SPACE;
      end else if (WR_EN && (WR_ADDR == AW'(gi))) begin
        r_cell <= WR_CHAR;
      end
    end
    assign w_buf[gi] = r_cell;
  end

  // Next-state logic; w_adv marks the cycle where the current step finishes
  always_comb begin
    w_adv    = 1'b0;
    w_nstate = r_state;
    w_nidx   = r_idx;
    w_nrow   = r_row;
    w_ncol   = r_col;
    case (r_state)
      ST_PWR: begin
        if (r_cnt == PW'(PWR_WAIT_CYC - 1)) begin
          w_adv    = 1'b1;
          w_nstate = ST_INIT;
          w_nidx   = 3'd0;
        end
      end
      ST_INIT: begin
        if (w_done) begin
          w_adv = 1'b1;
          if (r_idx == 3'(INIT_LEN - 1)) begin
            w_nstate = ST_IDLE;
          end else begin
            w_nidx = r_idx + 3'd1;
          end
        end
      end
      ST_IDLE: begin
        if (r_dirty || REFRESH) begin
          w_adv    = 1'b1;
          w_nstate = ST_ADDR;
          w_nrow   = 1'b0;
        end
      end
      ST_ADDR: begin
        if (w_done) begin
          w_adv    = 1'b1;
          w_nstate = ST_CHAR;
          w_ncol   = '0;
        end
      end
      ST_CHAR: begin
        if (w_done) begin
          w_adv = 1'b1;
          if (r_col == CLW'(COLS - 1)) begin
            if (r_row == 1'(ROWS - 1)) begin
              w_nstate = ST_IDLE;
            end else begin
              w_nstate = ST_ADDR;
              w_nrow   = 1'b1;
            end
          end else begin
            w_ncol = r_col + CLW'(1);
          end
        end
      end
      default: begin
        w_nstate = ST_PWR;
      end
    endcase
  end

  assign w_start      = w_adv && (w_nstate != ST_IDLE);
  assign w_init_fin   = (r_state == ST_INIT) && w_adv && (w_nstate == ST_IDLE);
  assign w_refresh_go = (r_state == ST_IDLE) && w_adv;
  assign w_cell       = (w_nrow ? IW'(COLS) : IW'(0)) + IW'(w_ncol);

  // The byte for the step being entered; the buffer is sampled as SETUP begins
  always_comb begin
    w_rs   = 1'b0;
    w_long = 1'b0;
    w_data = '0;
    case (w_nstate)
      ST_INIT: begin
        w_data = init_cmd(w_nidx);
        w_long = (w_data == CLEAR);
      end
      ST_ADDR: begin
        w_data = DDRAM | (w_nrow ? LINE2 : 8'h00);
      end
      ST_CHAR: begin
        w_rs   = 1'b1;
        w_data = w_buf[w_cell];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!SYNC_RST) begin
      r_state     <= ST_PWR;
      r_idx       <= '0;
      r_row       <= 1'b0;
      r_col       <= '0;
      r_cnt       <= '0;
      r_dirty     <= 1'b0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      r_row   <= w_nrow;
      r_col   <= w_ncol;
      r_busy  <= (w_nstate != ST_IDLE);
      r_cnt   <= (r_state == ST_PWR && !w_adv) ? r_cnt + PW'(1) : '0;
      // A write landing with the refresh start keeps DIRTY set
      r_dirty <= w_wr_ok || w_init_fin || (r_dirty && !w_refresh_go);
      if (w_init_fin) begin
        r_init_done <= 1'b1;
      end
    end
  end

  lcd_byte_tx #(
    .EN_CYC       (EN_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) u_tx (
    .CLOCK    (CLOCK),
    .SYNC_RST (SYNC_RST),
    .START    (w_start),
    .RS       (w_rs),
    .DATA     (w_data),
    .LONG     (w_long),
    .DONE     (w_done),
    .LCD_RS   (LCD_RS),
    .LCD_EN   (LCD_EN),
    .LCD_DATA (LCD_DATA)
  );

  assign LCD_RW    = 1'b0;
  assign INIT_DONE = r_init_done;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Scoreboard bench for lcd_text_ctrl: stimulus pushes the expected LCD byte stream,
// a monitor pops one entry per EN pulse and checks content and pulse timing.
module tb_lcd_text_ctrl;

  localparam int COLS   = 4;
  localparam int ROWS   = 2;
  localparam int NCELL  = 8;
  localparam int PWR_W  = 10;
  localparam int EN_CYC = 2;
  localparam int CMD_W  = 4;
  localparam int CLR_W  = 8;

  logic       CLOCK = 1'b0;
  logic       SYNC_RST = 1'b0;
  logic       WR_EN = 1'b0;
  logic [3:0] WR_ADDR = 4'd0;
  logic [7:0] WR_CHAR = 8'd0;
  logic       REFRESH = 1'b0;
  logic       LCD_RS, LCD_RW, LCD_EN, INIT_DONE, BUSY;
  logic [7:0] LCD_DATA;

  lcd_text_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .PWR_WAIT_CYC(PWR_W), .EN_CYC(EN_CYC),
    .CMD_WAIT_CYC(CMD_W), .CLR_WAIT_CYC(CLR_W)
  ) dut (
    .CLOCK(CLOCK), .SYNC_RST(SYNC_RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_CHAR(WR_CHAR), .REFRESH(REFRESH), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA), .INIT_DONE(INIT_DONE), .BUSY(BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    bit         first;
    bit         idone;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_buf [NCELL];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_bytes  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min_val);
    n_checks++;
    if (act < min_val) begin
      n_fail++;
      $display("FAIL %s: got %0d, required at least %0d", name, act, min_val);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d, input bit first, input bit idone);
    exp_t e;
    e.rs = rs; e.data = d; e.first = first; e.idone = idone;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38, 1'b1, 1'b0);
    push_byte(1'b0, 8'h38, 1'b0, 1'b0);
    push_byte(1'b0, 8'h0C, 1'b0, 1'b0);
    push_byte(1'b0, 8'h06, 1'b0, 1'b0);
    push_byte(1'b0, 8'h01, 1'b0, 1'b0);
  endtask

  // A full redraw: line address command, then that line's cells left to right
  task automatic push_redraw();
    for (int r = 0; r < ROWS; r++) begin
      push_byte(1'b0, (r == 1) ? 8'hC0 : 8'h80, (r == 0), 1'b1);
      for (int c = 0; c < COLS; c++) push_byte(1'b1, m_buf[r * COLS + c], 1'b0, 1'b1);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] ch);
    WR_EN = 1'b1; WR_ADDR = a; WR_CHAR = ch;
    if (int'(a) < NCELL) m_buf[a[2:0]] = ch;
    step();
    WR_EN = 1'b0;
  endtask

  task automatic pulse_refresh();
    REFRESH = 1'b1;
    step();
    REFRESH = 1'b0;
  endtask

  // Idle means BUSY low for three cycles in a row, so a chained refresh is not missed
  task automatic wait_quiet(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 2000) begin
      step();
      n++;
      quiet = BUSY ? 0 : quiet + 1;
    end
    check_ge({name, "_idle_reached"}, quiet, 3);
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : monitor
    logic       en_prev = 1'b0;
    int         cyc = 0, last_fall = 0, hi_cnt = 0, need = 0;
    bit         have_fall = 1'b0, prev_long = 1'b0;
    logic [8:0] held = '0;
    exp_t       e;
    forever begin
      @(negedge CLOCK);
      cyc++;
      if (SYNC_RST !== 1'b1) begin
        en_prev = 1'b0; have_fall = 1'b0; hi_cnt = 0;
      end else begin
        if (LCD_EN && !en_prev) begin
          n_bytes++;
          held = {LCD_RS, LCD_DATA};
          hi_cnt = 1;
          $display("byte %0d: rs=%0d data=0x%02h init_done=%0d", n_bytes, LCD_RS, LCD_DATA, INIT_DONE);
          check("rw_low", 32'(LCD_RW), 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got rs=%0d data=0x%02h, required no byte", LCD_RS, LCD_DATA);
          end else begin
            e = exp_q.pop_front();
            check("byte_value", 32'(held), 32'({e.rs, e.data}));
            check("init_done_flag", 32'(INIT_DONE), 32'(e.idone));
            if (have_fall) begin
              need = (prev_long ? CLR_W : CMD_W) + 1;
              if (e.first) check_ge("burst_gap", cyc - last_fall, need);
              else check("byte_gap", 32'(cyc - last_fall), 32'(need));
            end
          end
        end else if (LCD_EN) begin
          hi_cnt++;
          check("rs_data_stable", 32'({LCD_RS, LCD_DATA}), 32'(held));
        end else if (en_prev) begin
          check("en_width", 32'(hi_cnt), 32'(EN_CYC));
          last_fall = cyc;
          have_fall = 1'b1;
          prev_long = (held == 9'h001);
        end
        en_prev = LCD_EN;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] a, b;
    logic [7:0] c, d;
    int         kind, n0, busy_cnt, n;
    for (int i = 0; i < NCELL; i++) m_buf[i] = 8'h20;

    // Reset state
    repeat (3) step();
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_init_done", 32'(INIT_DONE), 32'd0);
    check("rst_en", 32'(LCD_EN), 32'd0);
    check("rst_rs", 32'(LCD_RS), 32'd0);
    check("rst_data", 32'(LCD_DATA), 32'd0);
    check("rst_rw", 32'(LCD_RW), 32'd0);

    // Power-up, init, then the automatic first redraw of blanks
    push_init();
    push_redraw();
    SYNC_RST = 1'b1;
    step();
    check("pwr_busy", 32'(BUSY), 32'd1);
    wait_quiet("boot");
    check("boot_init_done", 32'(INIT_DONE), 32'd1);
    check("boot_busy", 32'(BUSY), 32'd0);

    // Single write in IDLE; a REFRESH during the redraw must be dropped
    do_write(4'd5, 8'h41);
    push_redraw();
    repeat (6) step();
    check("busy_during_refresh", 32'(BUSY), 32'd1);
    pulse_refresh();
    wait_quiet("write5");

    // Write to cell 1 while cell 6 is on the bus: old value now, new value next redraw
    pulse_refresh();
    push_redraw();
    n0 = n_bytes;
    n = 0;
    while (n_bytes < n0 + 9 && n < 500) begin step(); n++; end
    check_ge("cell6_reached", n_bytes - n0, 9);
    do_write(4'd1, 8'h42);
    push_redraw();
    wait_quiet("late_write");

    // Out-of-range write
    n0 = n_bytes;
    do_write(4'd8, 8'h5A);
    busy_cnt = 0;
    repeat (30) begin step(); if (BUSY) busy_cnt++; end
    check("oor_busy_cycles", 32'(busy_cnt), 32'd0);
    check("oor_no_bytes", 32'(n_bytes - n0), 32'd0);

    // Randomized mix
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 3);
      a = 4'($urandom_range(0, NCELL - 1));
      b = 4'($urandom_range(0, NCELL - 1));
      c = 8'($urandom_range(8'h21, 8'h7E));
      d = 8'($urandom_range(8'h21, 8'h7E));
      case (kind)
        0: begin
          do_write(a, c);
          push_redraw();
          wait_quiet("rand_write");
        end
        1: begin
          push_redraw();
          pulse_refresh();
          wait_quiet("rand_refresh");
        end
        2: begin
          n0 = n_bytes;
          do_write(4'($urandom_range(NCELL, 15)), c);
          busy_cnt = 0;
          repeat (20) begin step(); if (BUSY) busy_cnt++; end
          check("rand_oor_busy", 32'(busy_cnt), 32'd0);
          check("rand_oor_bytes", 32'(n_bytes - n0), 32'd0);
        end
        default: begin
          // Second write lands on the refresh-start edge, so two redraws follow
          do_write(a, c);
          do_write(b, d);
          push_redraw();
          push_redraw();
          wait_quiet("rand_double");
        end
      endcase
    end

    // Reset in the middle of an EN pulse
    push_redraw();
    pulse_refresh();
    n = 0;
    while (LCD_EN !== 1'b1 && n < 100) begin step(); n++; end
    check("mid_pulse_en_seen", 32'(LCD_EN), 32'd1);
    SYNC_RST = 1'b0;
    step();
    check("mid_rst_en_drop", 32'(LCD_EN), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd1);
    check("mid_rst_init_done", 32'(INIT_DONE), 32'd0);
    exp_q.delete();
    for (int i = 0; i < NCELL; i++) m_buf[i] = 8'h20;
    step();
    SYNC_RST = 1'b1;
    // A write during PWR must be kept and shown by the first redraw
    do_write(4'd3, 8'h7A);
    push_init();
    push_redraw();
    wait_quiet("restart");
    check("restart_init_done", 32'(INIT_DONE), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
